// File: rtl/hfosc_power_sequencer_pkg.sv
// hfosc_seq_pkg: state encoding, counter sizing and parameter checks for the HFOSC sequencer.
// Shared by the sequencer top, its delay counter and the interface.
package hfosc_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_PWRUP  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ON     = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DIS    = 3'd5
    } seq_state_t;

    localparam int WAKE_CNT_W = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The counter is loaded with cycles-1, so it must hold values up to max_cycles-1.
    function automatic int cnt_width(input int max_cycles);
        int w;
        w = 1;
        while (w < 31 && (1 << w) < max_cycles) w++;
        return w;
    endfunction

    // Zero-length phases are rejected rather than clamped.
    function automatic bit params_valid(input int n_req, input int pu, input int settle, input int idle);
        return (n_req > 0) && (pu > 0) && (settle > 0) && (idle > 0);
    endfunction

endpackage

// File: rtl/hfosc_power_sequencer_if.sv
// hfosc_power_sequencer_if: request/grant and oscillator-pin bundle of the HFOSC sequencer.
// wake_count is present only when HFOSC_WAKE_CNT_EN is defined.
interface hfosc_power_sequencer_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic             osc_pu;
    logic             osc_en;
    logic             clk_ready;
`ifdef HFOSC_WAKE_CNT_EN
    logic [hfosc_seq_pkg::WAKE_CNT_W-1:0] wake_count;

    modport master (output req, input grant, input osc_pu, input osc_en, input clk_ready, input wake_count);
    modport slave  (input req, output grant, output osc_pu, output osc_en, output clk_ready, output wake_count);
`else
    modport master (output req, input grant, input osc_pu, input osc_en, input clk_ready);
    modport slave  (input req, output grant, output osc_pu, output osc_en, output clk_ready);
`endif
endinterface

// File: rtl/hfosc_power_sequencer_delay_counter.sv
// hfosc_delay_counter: loadable down-counter that stops at zero.
// One instance times every phase of the HFOSC sequencer.
module hfosc_delay_counter #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_value,
    output logic         o_zero
);
    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_value = r_count;
    assign o_zero  = (r_count == '0);
endmodule

// File: rtl/hfosc_power_sequencer.sv
// hfosc_power_sequencer: sequences SB_HFOSC CLKHFPU/CLKHFEN and grants its clock to requesters.
// Define HFOSC_WAKE_CNT_EN to add a saturating 16-bit power-up event counter (wake_count).
module hfosc_power_sequencer
    import hfosc_seq_pkg::*;
#(
    parameter int N_REQ         = 2,
    parameter int PU_CYCLES     = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int IDLE_CYCLES   = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    hfosc_power_sequencer_if.slave  if_seq
);
    localparam int CNT_W = cnt_width(max3(PU_CYCLES, SETTLE_CYCLES, IDLE_CYCLES));
    localparam logic [CNT_W-1:0] PU_LOAD     = CNT_W'(PU_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD   = CNT_W'(IDLE_CYCLES - 1);

    if (!params_valid(N_REQ, PU_CYCLES, SETTLE_CYCLES, IDLE_CYCLES)) begin : g_bad_params
        $error("hfosc_power_sequencer: all parameters must be non-zero");
    end

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [N_REQ-1:0] r_grant;
    logic             r_osc_pu;
    logic             r_osc_en;
    logic             r_clk_ready;
    logic             w_any_req;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_cnt_value;
    logic             w_cnt_zero;

    assign w_any_req = |if_seq.req;

    // HOLD checks req before expiry so a request on the expiry edge keeps the clock running.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_OFF:    if (w_any_req) w_next = ST_PWRUP;
            ST_PWRUP:  if (w_cnt_zero) w_next = ST_SETTLE;
            ST_SETTLE: if (w_cnt_zero) w_next = ST_ON;
            ST_ON:     if (!w_any_req) w_next = ST_HOLD;
            ST_HOLD: begin
                if (w_any_req)       w_next = ST_ON;
                else if (w_cnt_zero) w_next = ST_DIS;
            end
            ST_DIS:    w_next = w_any_req ? ST_SETTLE : ST_OFF;
            default:   w_next = ST_OFF;
        endcase
    end

    // Every state change reloads the counter; untimed states simply park it at zero.
    always_comb begin
        w_load     = (w_next != r_state);
        w_load_val = '0;
        case (w_next)
            ST_PWRUP:  w_load_val = PU_LOAD;
            ST_SETTLE: w_load_val = SETTLE_LOAD;
            ST_HOLD:   w_load_val = IDLE_LOAD;
            default:   w_load_val = '0;
        endcase
    end

    hfosc_delay_counter #(
        .W (CNT_W)
    ) u_delay (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_value    (w_cnt_value),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_OFF;
            r_grant     <= '0;
            r_osc_pu    <= 1'b0;
            r_osc_en    <= 1'b0;
            r_clk_ready <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_grant     <= (w_next == ST_ON) ? if_seq.req : '0;
            r_osc_pu    <= (w_next != ST_OFF);
            r_osc_en    <= (w_next == ST_SETTLE) || (w_next == ST_ON) || (w_next == ST_HOLD);
            r_clk_ready <= (w_next == ST_ON) || (w_next == ST_HOLD);
        end
    end

    assign if_seq.grant     = r_grant;
    assign if_seq.osc_pu    = r_osc_pu;
    assign if_seq.osc_en    = r_osc_en;
    assign if_seq.clk_ready = r_clk_ready;

`ifdef HFOSC_WAKE_CNT_EN
    logic [WAKE_CNT_W-1:0] r_wake_count;
    logic                  w_wake_evt;

    assign w_wake_evt = ((r_state == ST_OFF) && (w_next == ST_PWRUP)) ||
                        ((r_state == ST_DIS) && (w_next == ST_SETTLE));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wake_count <= '0;
        end else if (w_wake_evt && (r_wake_count != '1)) begin
            r_wake_count <= r_wake_count + 1'b1;
        end
    end

    assign if_seq.wake_count = r_wake_count;
`endif

    // Untimed states always hold a parked (zero) counter.
    a_cnt_parked: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        ((r_state == ST_OFF) || (r_state == ST_ON)) |-> (w_cnt_value == '0));

endmodule

// File: tb/tb_hfosc_power_sequencer.sv
// tb_hfosc_power_sequencer: directed vectors with a scoreboard queue and a decoupled monitor.
// Build with HFOSC_WAKE_CNT_EN defined to also check wake_count.
module tb_hfosc_power_sequencer;

    typedef struct {
        int          cyc;
        string       tag;
        logic [1:0]  grant;
        logic        pu;
        logic        en;
        logic        rdy;
        logic [15:0] wake;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          edge_cnt;
    int          vectors;
    int          miscompares;
    bit          probe_flag;
    logic [15:0] exp_wake;
    event        probe_ev;
    exp_t        sb[$];

    hfosc_power_sequencer_if #(.N_REQ(2)) bus ();

    hfosc_power_sequencer #(
        .N_REQ         (2),
        .PU_CYCLES     (4),
        .SETTLE_CYCLES (8),
        .IDLE_CYCLES   (16)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .if_seq  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive req at a negedge and expect the outputs after the following posedge.
    task automatic cyc(input logic [1:0] r, input string tag, input logic [1:0] g,
                       input logic pu, input logic en, input logic rdy);
        exp_t e;
        bus.req = r;
        e.cyc = edge_cnt + 1;
        e.tag = tag;
        e.grant = g;
        e.pu = pu;
        e.en = en;
        e.rdy = rdy;
        e.wake = exp_wake;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Expect the outputs right now, without waiting for a clock edge.
    task automatic probe(input string tag);
        exp_t e;
        e.cyc = edge_cnt;
        e.tag = tag;
        e.grant = 2'b00;
        e.pu = 1'b0;
        e.en = 1'b0;
        e.rdy = 1'b0;
        e.wake = exp_wake;
        sb.push_back(e);
        probe_flag = 1'b1;
        ->probe_ev;
        #2;
    endtask

    task automatic cold_start(input logic [1:0] r);
        exp_wake = exp_wake + 16'd1;
        for (int i = 0; i < 4; i++) cyc(r, "pwrup", 2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(r, "settle", 2'b00, 1'b1, 1'b1, 1'b0);
        cyc(r, "cold_on", r, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic hold_16(input string tag);
        for (int i = 0; i < 16; i++) cyc(2'b00, tag, 2'b00, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [15:0] got_wake;
        bit          ok;
        forever begin
            @(posedge clk or probe_ev);
            if (probe_flag) probe_flag = 1'b0;
            else edge_cnt++;
            #1;
            while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
                e = sb.pop_front();
                got_wake = 16'd0;
                ok = (bus.grant === e.grant) && (bus.osc_pu === e.pu) &&
                     (bus.osc_en === e.en) && (bus.clk_ready === e.rdy);
`ifdef HFOSC_WAKE_CNT_EN
                got_wake = bus.wake_count;
                ok = ok && (got_wake === e.wake);
`endif
                vectors++;
                if (!ok) begin
                    miscompares++;
                    $display("FAIL %s @edge %0d: got grant=%b pu=%b en=%b rdy=%b wake=%0d, want grant=%b pu=%b en=%b rdy=%b wake=%0d",
                             e.tag, edge_cnt, bus.grant, bus.osc_pu, bus.osc_en, bus.clk_ready, got_wake,
                             e.grant, e.pu, e.en, e.rdy, e.wake);
                end else begin
                    $display("vec %0d %s @edge %0d ok grant=%b pu=%b en=%b rdy=%b",
                             vectors, e.tag, edge_cnt, bus.grant, bus.osc_pu, bus.osc_en, bus.clk_ready);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors still queued, required 0", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n       = 1'b0;
        bus.req     = 2'b00;
        exp_wake    = 16'd0;
        edge_cnt    = 0;
        vectors     = 0;
        miscompares = 0;
        probe_flag  = 1'b0;
        repeat (2) @(negedge clk);
        probe("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Cold start: grant appears after the 13th edge.
        cold_start(2'b01);

        // Shared, non-exclusive grant.
        cyc(2'b11, "share_both", 2'b11, 1'b1, 1'b1, 1'b1);
        cyc(2'b10, "share_drop0", 2'b10, 1'b1, 1'b1, 1'b1);
        cyc(2'b10, "share_keep", 2'b10, 1'b1, 1'b1, 1'b1);

        // Early return from HOLD, no re-settle.
        for (int i = 0; i < 3; i++) cyc(2'b00, "hold_early", 2'b00, 1'b1, 1'b1, 1'b1);
        cyc(2'b01, "hold_early_on", 2'b01, 1'b1, 1'b1, 1'b1);

        // Idle shutdown: EN drops before PU.
        hold_16("idle_hold");
        cyc(2'b00, "idle_dis", 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, "idle_off", 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, "off_stay", 2'b00, 1'b0, 1'b0, 1'b0);

        // Second cold start from the other requester.
        cold_start(2'b10);

        // DIS re-request goes straight to SETTLE with PU held high.
        hold_16("dis_hold");
        cyc(2'b00, "dis", 2'b00, 1'b1, 1'b0, 1'b0);
        exp_wake = exp_wake + 16'd1;
        for (int i = 0; i < 8; i++) cyc(2'b01, "dis_settle", 2'b00, 1'b1, 1'b1, 1'b0);
        cyc(2'b01, "dis_on", 2'b01, 1'b1, 1'b1, 1'b1);

        // HOLD rescue: request arrives on the idle-expiry edge.
        hold_16("rescue_hold");
        cyc(2'b10, "rescue_on", 2'b10, 1'b1, 1'b1, 1'b1);
        cyc(2'b10, "rescue_keep", 2'b10, 1'b1, 1'b1, 1'b1);

        // Reset in the middle of SETTLE.
        hold_16("pre_rst_hold");
        cyc(2'b00, "pre_rst_dis", 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, "pre_rst_off", 2'b00, 1'b0, 1'b0, 1'b0);
        exp_wake = exp_wake + 16'd1;
        for (int i = 0; i < 4; i++) cyc(2'b01, "pre_rst_pwrup", 2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(2'b01, "pre_rst_settle", 2'b00, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        exp_wake = 16'd0;
        probe("rst_async");
        cyc(2'b01, "rst_held", 2'b00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cold_start(2'b01);
        cyc(2'b01, "final_on", 2'b01, 1'b1, 1'b1, 1'b1);

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            miscompares += sb.size();
            $display("FAIL scoreboard_drain: %0d expected vectors never compared, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
